uart_rx_ctrl: RTL and testbench

- Controller that configures and sequences the UART receiver.
- Auto-baud calibration: measures a 0x55 sync frame on the raw RX line and programs the receiver's clks_per_bit. It holds the receiver in reset while calibrating.
- Manual clks_per_bit load.
- Buffers received bytes in a small first-word-fall-through FIFO with a valid/ready consumer port.
- Sits between the RX line/receiver and the host-side byte consumer.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths, sync-frame constants and controller state encoding for the UART receive path.
// Pure declarations: no latency, no flow control.
package uart_pkg;

  localparam int CPB_W           = 10;
  localparam int MEAS_W          = 13;
  localparam int SYNC_FALL_EDGES = 5;

  typedef enum logic [2:0] {
    RUN,
    ARM,
    MEASURE,
    SETTLE,
    FAIL
  } ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; dout shows the head with zero latency.
// A push into a full FIFO succeeds only with a same-cycle pop; otherwise the caller drops it.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: auto-baud from a 0x55 sync frame, manual clks_per_bit load, byte FIFO.
// Outputs registered (FIFO head/valid/count combinational); bytes arriving at a full FIFO are dropped and flagged.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DEFAULT_CPB = 868,
  parameter int MIN_CPB     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_line,
  input  logic                     cal_start,
  input  logic                     cfg_load,
  input  logic [CPB_W-1:0]         cfg_cpb,
  input  logic                     status_clr,
  input  logic                     rx_eoc,
  input  logic [7:0]               rx_data,
  output logic                     uart_rst_n,
  output logic [CPB_W-1:0]         clks_per_bit,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     locked,
  output logic                     cal_busy,
  output logic                     cal_error,
  output logic                     overflow
);

  ctrl_state_t       state_q, state_d;
  logic              sync1_q, sync2_q, rx_prev_q, eoc_prev_q;
  logic [MEAS_W-1:0] meas_q, meas_d;
  logic [2:0]        edges_q, edges_d;
  logic [CPB_W-1:0]  cpb_q, cpb_d;
  logic [CPB_W-1:0]  saved_q, saved_d;
  logic              uart_rst_n_q, uart_rst_n_d;
  logic              locked_q, locked_d;
  logic              cal_busy_q, cal_busy_d;
  logic              cal_error_q, cal_error_d;
  logic              overflow_q, overflow_d;

  logic              rx_fall, eoc_rise, last_edge, meas_max;
  logic [MEAS_W-1:0] meas_inc, settle_target;
  logic [CPB_W-1:0]  cand;
  logic              fifo_push, fifo_full, fifo_empty;

  assign rx_fall       = rx_prev_q & ~sync2_q;
  assign eoc_rise      = rx_eoc & ~eoc_prev_q;
  assign meas_inc      = meas_q + MEAS_W'(1);
  assign meas_max      = (meas_q == '1);
  // Counter value at the 5th falling edge spans 8 bit times; divide by 8.
  assign cand          = meas_inc[MEAS_W-1:3];
  assign last_edge     = (edges_q == 3'(SYNC_FALL_EDGES - 1));
  assign settle_target = MEAS_W'({cpb_q, 1'b0});
  assign fifo_push     = (state_q == RUN) && eoc_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      eoc_prev_q <= 1'b0;
    end else begin
      sync1_q    <= rx_line;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      eoc_prev_q <= rx_eoc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      meas_q       <= '0;
      edges_q      <= '0;
      cpb_q        <= CPB_W'(DEFAULT_CPB);
      saved_q      <= CPB_W'(DEFAULT_CPB);
      uart_rst_n_q <= 1'b0;
      locked_q     <= 1'b1;
      cal_busy_q   <= 1'b0;
      cal_error_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      meas_q       <= meas_d;
      edges_q      <= edges_d;
      cpb_q        <= cpb_d;
      saved_q      <= saved_d;
      uart_rst_n_q <= uart_rst_n_d;
      locked_q     <= locked_d;
      cal_busy_q   <= cal_busy_d;
      cal_error_q  <= cal_error_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (cal_start) state_d = ARM;
        ARM:     if (rx_fall) state_d = MEASURE;
        MEASURE: begin
          if (meas_max) state_d = FAIL;
          else if (rx_fall && last_edge)
            state_d = (cand < CPB_W'(MIN_CPB)) ? FAIL : SETTLE;
        end
        SETTLE:  if (sync2_q && (meas_inc == settle_target)) state_d = RUN;
        FAIL:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    meas_d       = meas_q;
    edges_d      = edges_q;
    cpb_d        = cpb_q;
    saved_d      = saved_q;
    cal_error_d  = cal_error_q;
    overflow_d   = overflow_q;
    cal_busy_d   = (state_d == ARM) || (state_d == MEASURE) || (state_d == SETTLE);
    locked_d     = !cal_busy_d;
    uart_rst_n_d = (state_d == RUN);

    if (status_clr) begin
      cal_error_d = 1'b0;
      overflow_d  = 1'b0;
    end

    if (cfg_load) begin
      cpb_d = cfg_cpb;
    end else begin
      case (state_q)
        RUN: begin
          if (cal_start) begin
            saved_d = cpb_q;
            meas_d  = '0;
            edges_d = '0;
          end
        end
        ARM: begin
          if (rx_fall) begin
            meas_d  = '0;
            edges_d = 3'd1;
          end
        end
        MEASURE: begin
          meas_d = meas_inc;
          if (rx_fall) edges_d = edges_q + 3'd1;
          if (!meas_max && rx_fall && last_edge && (cand >= CPB_W'(MIN_CPB))) begin
            cpb_d  = cand;
            meas_d = '0;
          end
        end
        // Reuse the measurement counter as the idle-high run length.
        SETTLE:  meas_d = sync2_q ? meas_inc : '0;
        FAIL: begin
          cpb_d       = saved_q;
          cal_error_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (fifo_push && fifo_full && !(m_ready && !fifo_empty)) overflow_d = 1'b1;
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (m_ready),
    .din   (rx_data),
    .dout  (m_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid      = !fifo_empty;
  assign uart_rst_n   = uart_rst_n_q;
  assign clks_per_bit = cpb_q;
  assign locked       = locked_q;
  assign cal_busy     = cal_busy_q;
  assign cal_error    = cal_error_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: reset, auto-baud, failure paths, FIFO full/overflow, cfg_load priority.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic       cal_start;
  logic       cfg_load;
  logic [9:0] cfg_cpb;
  logic       status_clr;
  logic       rx_eoc;
  logic [7:0] rx_data;
  logic       uart_rst_n;
  logic [9:0] clks_per_bit;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] fifo_count;
  logic       locked;
  logic       cal_busy;
  logic       cal_error;
  logic       overflow;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(8), .DEFAULT_CPB(868), .MIN_CPB(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_line      (rx_line),
    .cal_start    (cal_start),
    .cfg_load     (cfg_load),
    .cfg_cpb      (cfg_cpb),
    .status_clr   (status_clr),
    .rx_eoc       (rx_eoc),
    .rx_data      (rx_data),
    .uart_rst_n   (uart_rst_n),
    .clks_per_bit (clks_per_bit),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_count   (fifo_count),
    .locked       (locked),
    .cal_busy     (cal_busy),
    .cal_error    (cal_error),
    .overflow     (overflow)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_cal_start();
    cal_start = 1'b1; tick(1); cal_start = 1'b0;
  endtask

  task automatic pulse_status_clr();
    status_clr = 1'b1; tick(1); status_clr = 1'b0;
  endtask

  task automatic pulse_eoc(input logic [7:0] d);
    rx_data = d; rx_eoc = 1'b1; tick(1); rx_eoc = 1'b0; tick(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (cal_busy === 1'b1 && n < budget) begin tick(1); n++; end
    checks++; if (cal_busy !== 1'b0) $display("FAIL %s: cal_busy still %b after %0d cycles", name, cal_busy, budget); else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_line = 1'b1; cal_start = 1'b0; cfg_load = 1'b0; cfg_cpb = '0;
    status_clr = 1'b0; rx_eoc = 1'b0; rx_data = '0; m_ready = 1'b0;
    tick(3);
    checks++; if (clks_per_bit !== 10'd868) $display("FAIL rst_cpb: got %0d want 868", clks_per_bit); else passes++;
    checks++; if (uart_rst_n !== 1'b0) $display("FAIL rst_uart_rst_n: got %b want 0", uart_rst_n); else passes++;
    checks++; if (locked !== 1'b1 || cal_busy !== 1'b0) $display("FAIL rst_lock_busy: got %b%b want 10", locked, cal_busy); else passes++;
    checks++; if (cal_error !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_sticky: got %b%b want 00", cal_error, overflow); else passes++;
    checks++; if (m_valid !== 1'b0 || fifo_count !== 4'd0 || m_data !== 8'h00) $display("FAIL rst_fifo: got v=%b c=%0d d=%h want 0 0 00", m_valid, fifo_count, m_data); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (uart_rst_n !== 1'b1) $display("FAIL rst_release_uart_rst_n: got %b want 1", uart_rst_n); else passes++;
    tick(2);
  endtask

  task automatic test_autobaud();
    logic [7:0]  d;
    logic [10:0] fr;
    d  = 8'h55;
    fr = {1'b1, 1'b0, d, 1'b0};
    pulse_cal_start();
    checks++; if (cal_busy !== 1'b1 || uart_rst_n !== 1'b0 || locked !== 1'b0) $display("FAIL ab_arm: got busy=%b rstn=%b lock=%b want 1 0 0", cal_busy, uart_rst_n, locked); else passes++;
    for (int i = 0; i < 11; i++) begin
      rx_line = fr[i];
      tick(434);
      if (i == 4) begin
        checks++; if (cal_busy !== 1'b1) $display("FAIL ab_midframe_busy: got %b want 1", cal_busy); else passes++;
      end
    end
    rx_line = 1'b1;
    tick(400);
    checks++; if (cal_busy !== 1'b1 || uart_rst_n !== 1'b0) $display("FAIL ab_settling: got busy=%b rstn=%b want 1 0", cal_busy, uart_rst_n); else passes++;
    checks++; if (clks_per_bit !== 10'd434) $display("FAIL ab_cpb_settle: got %0d want 434", clks_per_bit); else passes++;
    wait_idle("ab_done_timeout", 200);
    checks++; if (clks_per_bit !== 10'd434 || locked !== 1'b1 || cal_error !== 1'b0 || uart_rst_n !== 1'b1) $display("FAIL ab_done: got cpb=%0d lock=%b err=%b rstn=%b want 434 1 0 1", clks_per_bit, locked, cal_error, uart_rst_n); else passes++;
  endtask

  task automatic test_glitch_cal();
    pulse_cal_start();
    for (int e = 0; e < 5; e++) begin rx_line = 1'b0; tick(5); rx_line = 1'b1; tick(35); end
    wait_idle("gl40_timeout", 200);
    checks++; if (clks_per_bit !== 10'd20 || locked !== 1'b1 || cal_error !== 1'b0) $display("FAIL gl40: got cpb=%0d lock=%b err=%b want 20 1 0", clks_per_bit, locked, cal_error); else passes++;
    cfg_cpb = 10'd868; cfg_load = 1'b1; tick(1); cfg_load = 1'b0;
    checks++; if (clks_per_bit !== 10'd868) $display("FAIL gl_reload: got %0d want 868", clks_per_bit); else passes++;
    pulse_cal_start();
    for (int e = 0; e < 5; e++) begin rx_line = 1'b0; tick(5); rx_line = 1'b1; tick(3); end
    tick(10);
    checks++; if (clks_per_bit !== 10'd868 || cal_error !== 1'b1 || locked !== 1'b1 || cal_busy !== 1'b0) $display("FAIL gl8_fail: got cpb=%0d err=%b lock=%b busy=%b want 868 1 1 0", clks_per_bit, cal_error, locked, cal_busy); else passes++;
    pulse_status_clr();
    checks++; if (cal_error !== 1'b0) $display("FAIL gl_status_clr: got %b want 0", cal_error); else passes++;
  endtask

  task automatic test_timeout();
    pulse_cal_start();
    rx_line = 1'b0;
    tick(8100);
    checks++; if (cal_busy !== 1'b1) $display("FAIL to_before: got busy=%b want 1", cal_busy); else passes++;
    tick(200);
    checks++; if (cal_busy !== 1'b0 || cal_error !== 1'b1 || clks_per_bit !== 10'd868 || locked !== 1'b1) $display("FAIL to_after: got busy=%b err=%b cpb=%0d lock=%b want 0 1 868 1", cal_busy, cal_error, clks_per_bit, locked); else passes++;
    rx_line = 1'b1;
    tick(5);
    pulse_status_clr();
  endtask

  task automatic test_fifo_overflow();
    m_ready = 1'b1;
    tick(3);
    checks++; if (fifo_count !== 4'd0 || m_valid !== 1'b0) $display("FAIL ff_empty_pop: got c=%0d v=%b want 0 0", fifo_count, m_valid); else passes++;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) pulse_eoc(8'(i));
    checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0) $display("FAIL ff_full: got c=%0d ovf=%b want 8 0", fifo_count, overflow); else passes++;
    pulse_eoc(8'h09);
    pulse_eoc(8'h0A);
    checks++; if (fifo_count !== 4'd8 || overflow !== 1'b1 || m_data !== 8'h01 || m_valid !== 1'b1) $display("FAIL ff_overflow: got c=%0d ovf=%b d=%h v=%b want 8 1 01 1", fifo_count, overflow, m_data, m_valid); else passes++;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (m_data !== 8'(i)) $display("FAIL ff_drain%0d: got %h want %h", i, m_data, 8'(i)); else passes++;
      tick(1);
    end
    m_ready = 1'b0;
    checks++; if (fifo_count !== 4'd0 || m_valid !== 1'b0) $display("FAIL ff_drained: got c=%0d v=%b want 0 0", fifo_count, m_valid); else passes++;
    pulse_status_clr();
    checks++; if (overflow !== 1'b0) $display("FAIL ff_ovf_clr: got %b want 0", overflow); else passes++;
    for (int i = 1; i <= 8; i++) pulse_eoc(8'(8'h10 + i));
    rx_data = 8'h19; rx_eoc = 1'b1; m_ready = 1'b1;
    tick(1);
    rx_eoc = 1'b0; m_ready = 1'b0;
    checks++; if (fifo_count !== 4'd8 || overflow !== 1'b0 || m_data !== 8'h12) $display("FAIL ff_push_pop_full: got c=%0d ovf=%b d=%h want 8 0 12", fifo_count, overflow, m_data); else passes++;
    tick(1);
    m_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      checks++; if (m_data !== 8'(8'h10 + i)) $display("FAIL ff_order%0d: got %h want %h", i, m_data, 8'(8'h10 + i)); else passes++;
      tick(1);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_cfg_load();
    pulse_cal_start();
    rx_line = 1'b0; tick(5); rx_line = 1'b1; tick(10);
    pulse_eoc(8'h77);
    checks++; if (cal_busy !== 1'b1 || fifo_count !== 4'd0) $display("FAIL cl_measuring: got busy=%b c=%0d want 1 0", cal_busy, fifo_count); else passes++;
    cfg_cpb = 10'd100; cfg_load = 1'b1; cal_start = 1'b1;
    tick(1);
    cfg_load = 1'b0; cal_start = 1'b0;
    checks++; if (clks_per_bit !== 10'd100 || cal_busy !== 1'b0 || locked !== 1'b1) $display("FAIL cl_load: got cpb=%0d busy=%b lock=%b want 100 0 1", clks_per_bit, cal_busy, locked); else passes++;
    tick(1);
    checks++; if (cal_busy !== 1'b0 || uart_rst_n !== 1'b1) $display("FAIL cl_run: got busy=%b rstn=%b want 0 1", cal_busy, uart_rst_n); else passes++;
    cfg_cpb = 10'd200; cfg_load = 1'b1; cal_start = 1'b1;
    tick(1);
    cfg_load = 1'b0; cal_start = 1'b0;
    tick(2);
    checks++; if (clks_per_bit !== 10'd200 || cal_busy !== 1'b0 || uart_rst_n !== 1'b1) $display("FAIL cl_wins_run: got cpb=%0d busy=%b rstn=%b want 200 0 1", clks_per_bit, cal_busy, uart_rst_n); else passes++;
  endtask

  initial begin
    test_reset();
    test_autobaud();
    test_glitch_cal();
    test_timeout();
    test_fifo_overflow();
    test_cfg_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
